clk_div_bank: RTL and testbench

- Parametrised successor to the fixed divide-by-2 / divide-by-4 clock generators.
- Produces NUM_CH independent divided clocks, each with a matching one-cycle tick enable.
- Each channel's ratio is runtime-programmable; a new ratio takes effect only at that channel's period boundary, so there are no runt pulses.
- Sits at the top level beside the processor wrapper and feeds processor, regfile, dmem and peripheral clocks/enables from the single master clock.

---
 rtl/clk_div_bank_if.sv | 25 ++
 rtl/clk_div_bank.sv | 91 +++++++++
 tb/tb_clk_div_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/clk_div_bank_if.sv
// Configuration and divided-clock bundle for clk_div_bank.
// The master side programs ratios; the slave side (the divider bank) drives the clocks and ticks.
interface clk_div_bank_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic              cfg_wr;
  logic [3:0]        cfg_sel;
  logic [CNT_W-1:0]  cfg_div;
  logic              sync_req;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] div_tick;
  logic [NUM_CH-1:0] pending;
  logic              cfg_err;

  modport master (
    output cfg_wr, cfg_sel, cfg_div, sync_req,
    input  div_clk, div_tick, pending, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_sel, cfg_div, sync_req,
    output div_clk, div_tick, pending, cfg_err
  );
endinterface

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with tick enables.
// A new ratio is shadowed and only swapped in at the channel's period boundary.
module clk_div_bank #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic          clock_i,
  input  logic          reset_i,
  clk_div_bank_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);

  logic sel_ok;
  logic div_ok;
  logic cfg_ok;
  logic cfg_err_q;

  // All four select bits take part in the range check.
  assign sel_ok = {1'b0, bus.cfg_sel} < NUM_CH_L;
  assign div_ok = bus.cfg_div >= CNT_W'(2);
  assign cfg_ok = sel_ok && div_ok;

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_wr && !cfg_ok;
    end
  end

  assign bus.cfg_err = cfg_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             clk_q;
    logic             tick_q;
    logic             wr_hit;
    logic             wrap;
    logic [CNT_W:0]   half;

    always_comb begin
      wr_hit = bus.cfg_wr && cfg_ok && (bus.cfg_sel == 4'(gi));
      wrap   = (cnt_q == div_q - CNT_W'(1));
      div_d  = div_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      cnt_d  = cnt_q + CNT_W'(1);
      if (bus.sync_req || wrap) begin
        cnt_d = '0;
        if (pend_q) begin
          div_d  = shd_q;
          pend_d = 1'b0;
        end
      end
      // A write landing on a wrap/sync edge only arms the following boundary.
      if (wr_hit) begin
        shd_d  = bus.cfg_div;
        pend_d = 1'b1;
      end
      half = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
    end

    // Outputs are computed from next-state so they line up with the held count.
    always_ff @(posedge clock_i) begin
      if (!reset_i) begin
        div_q  <= DEF_DIV;
        shd_q  <= DEF_DIV;
        cnt_q  <= DEF_DIV - CNT_W'(1);
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        shd_q  <= shd_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        clk_q  <= ({1'b0, cnt_d} < half);
        tick_q <= (cnt_d == '0);
      end
    end

    assign bus.div_clk[gi]  = clk_q;
    assign bus.div_tick[gi] = tick_q;
    assign bus.pending[gi]  = pend_q;
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a per-channel period model predicts every cycle's
// outputs, and an independent monitor compares them against the DUT on the falling edge.
module tb_clk_div_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DEF    = 2;

  typedef struct {
    logic [NUM_CH-1:0] dclk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
    logic              err;
  } exp_t;

  logic clk;
  logic rst_n;
  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 1'b0;

  // Reference model: ratio, shadow ratio, pending flag and position within the period.
  int ratio[NUM_CH];
  int shadow[NUM_CH];
  bit armed[NUM_CH];
  int pos[NUM_CH];

  task automatic model_edge(input bit r_n, input bit wr, input int sel, input int dv,
                            input bit sync);
    exp_t e;
    bit ok;
    ok = (sel < NUM_CH) && (dv >= 2);
    e.err = r_n && wr && !ok;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!r_n) begin
        ratio[c] = DEF; shadow[c] = DEF; armed[c] = 0; pos[c] = DEF - 1;
        e.dclk[c] = 1'b0; e.tick[c] = 1'b0; e.pend[c] = 1'b0;
      end else begin
        if (sync || pos[c] == ratio[c] - 1) begin
          pos[c] = 0;
          if (armed[c]) begin
            ratio[c] = shadow[c];
            armed[c] = 0;
          end
        end else begin
          pos[c] = pos[c] + 1;
        end
        if (wr && ok && sel == c) begin
          shadow[c] = dv;
          armed[c] = 1;
        end
        e.dclk[c] = (pos[c] < (ratio[c] + 1) / 2);
        e.tick[c] = (pos[c] == 0);
        e.pend[c] = armed[c];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r_n, input bit wr, input int sel, input int dv, input bit sync);
    rst_n        = r_n;
    bus.cfg_wr   = wr;
    bus.cfg_sel  = 4'(sel);
    bus.cfg_div  = CNT_W'(dv);
    bus.sync_req = sync;
    @(posedge clk);
    #1;
    model_edge(r_n, wr, sel, dv, sync);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst_n = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_sel = '0; bus.cfg_div = '0; bus.sync_req = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    idle(6);
    cyc(1'b1, 1'b1, 1, 5, 1'b0);
    idle(14);
    cyc(1'b1, 1'b1, 2, 4, 1'b0);
    cyc(1'b1, 1'b1, 2, 6, 1'b0);
    idle(14);
    cyc(1'b1, 1'b1, 0, 1, 1'b0);
    cyc(1'b1, 1'b1, 7, 3, 1'b0);
    idle(4);
    cyc(1'b1, 1'b1, 3, 8, 1'b0);
    idle(13);
    cyc(1'b1, 1'b1, 3, 3, 1'b1);
    idle(20);
    cyc(1'b1, 1'b1, 0, 7, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 1'b1, 0, 9, 1'b1);
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 5) == 0),
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 12)),
          ($urandom_range(0, 59) == 0));
    end
    stim_done = 1'b1;
  end

  task automatic check1(input string name, input logic [NUM_CH-1:0] act,
                        input logic [NUM_CH-1:0] req, input int cyc_no);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle the DUT presents outputs.
  initial begin
    exp_t e;
    int n;
    int budget;
    n = 0;
    budget = 0;
    while (!(stim_done && exp_q.size() == 0)) begin
      @(negedge clk);
      budget++;
      if (budget > 20000) begin
        miscompares++;
        $display("FAIL timeout: monitor budget %0d exceeded, %0d pending", budget, exp_q.size());
        break;
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n++;
        check1("div_clk", bus.div_clk, e.dclk, n);
        check1("div_tick", bus.div_tick, e.tick, n);
        check1("pending", bus.pending, e.pend, n);
        check1("cfg_err", {{(NUM_CH-1){1'b0}}, bus.cfg_err}, {{(NUM_CH-1){1'b0}}, e.err}, n);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
